// File: rtl/fsk_modem_pkg.sv
// fsk_modem_pkg: shared constants and quarter-wave sine table for the FSK modem
package fsk_modem_pkg;
   localparam int PHASE_W = 8;
   localparam int SAMPLE_W = 6;
   localparam logic [7:0] TIMEOUT = 8'd63;
   localparam logic [7:0] MARK_INC_RST = 8'h20;
   localparam logic [7:0] SPACE_INC_RST = 8'h10;
   localparam logic [7:0] THRESH_RST = 8'd12;
   localparam logic [7:0] ADDR_MARK = 8'h00;
   localparam logic [7:0] ADDR_SPACE = 8'h01;
   localparam logic [7:0] ADDR_THRESH = 8'h02;

   function automatic logic [4:0] quarter_sine(input logic [3:0] idx);
      logic [4:0] t;
      case (idx)
         4'd0: t = 5'd0;
         4'd1: t = 5'd3;
         4'd2: t = 5'd6;
         4'd3: t = 5'd9;
         4'd4: t = 5'd12;
         4'd5: t = 5'd15;
         4'd6: t = 5'd17;
         4'd7: t = 5'd20;
         4'd8: t = 5'd22;
         4'd9: t = 5'd24;
         4'd10: t = 5'd26;
         4'd11: t = 5'd27;
         4'd12: t = 5'd29;
         4'd13: t = 5'd30;
         4'd14: t = 5'd30;
         default: t = 5'd31;
      endcase
      return t;
   endfunction

   // mirrored index 16 is the crest, one past the end of the 16-entry table
   function automatic logic [SAMPLE_W-1:0] sine_sample(input logic [5:0] p);
      logic [4:0] k;
      logic [4:0] mag;
      k = p[4] ? 5'd16 - {1'b0, p[3:0]} : {1'b0, p[3:0]};
      mag = k[4] ? 5'd31 : quarter_sine(k[3:0]);
      return p[5] ? 6'd32 - {1'b0, mag} : 6'd32 + {1'b0, mag};
   endfunction
endpackage

// File: rtl/fsk_modem_if.sv
// fsk_modem_if: SPI configuration pins between the pin frame and the config block
interface fsk_modem_if;
   logic cs_n;
   logic sck;
   logic mosi;
   modport master (output cs_n, output sck, output mosi);
   modport slave (input cs_n, input sck, input mosi);
endinterface

// File: rtl/fsk_spi_cfg.sv
// fsk_spi_cfg: write-only mode-0 SPI slave holding the modem config registers
module fsk_spi_cfg
   import fsk_modem_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   fsk_modem_if.slave spi_i,
   output logic [7:0] mark_inc_o,
   output logic [7:0] space_inc_o,
   output logic [7:0] thresh_o
);
   logic [1:0] cs_sync_q, sck_sync_q, mosi_sync_q;
   logic cs_prev_q, sck_prev_q;
   logic [15:0] shift_q, shift_d;
   logic [4:0] bits_q, bits_d;
   logic [7:0] mark_q, mark_d, space_q, space_d, thresh_q, thresh_d;
   logic cs_fall, cs_rise, sck_rise, commit;

   always_ff @(posedge clk) begin
      cs_sync_q <= {cs_sync_q[0], spi_i.cs_n};
      sck_sync_q <= {sck_sync_q[0], spi_i.sck};
      mosi_sync_q <= {mosi_sync_q[0], spi_i.mosi};
   end

   always_comb begin
      cs_fall = ~cs_sync_q[1] & cs_prev_q;
      cs_rise = cs_sync_q[1] & ~cs_prev_q;
      sck_rise = sck_sync_q[1] & ~sck_prev_q & ~cs_sync_q[1];
      shift_d = sck_rise ? {shift_q[14:0], mosi_sync_q[1]} : shift_q;
      bits_d = cs_fall ? 5'd0 : (sck_rise && bits_q != 5'd17) ? bits_q + 5'd1 : bits_q;
      commit = cs_rise && bits_q == 5'd16;
      mark_d = (commit && shift_q[15:8] == ADDR_MARK) ? shift_q[7:0] : mark_q;
      space_d = (commit && shift_q[15:8] == ADDR_SPACE) ? shift_q[7:0] : space_q;
      thresh_d = (commit && shift_q[15:8] == ADDR_THRESH) ? shift_q[7:0] : thresh_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cs_prev_q <= 1'b1;
         sck_prev_q <= 1'b0;
         shift_q <= 16'd0;
         bits_q <= 5'd0;
         mark_q <= MARK_INC_RST;
         space_q <= SPACE_INC_RST;
         thresh_q <= THRESH_RST;
      end else begin
         cs_prev_q <= cs_sync_q[1];
         sck_prev_q <= sck_sync_q[1];
         shift_q <= shift_d;
         bits_q <= bits_d;
         mark_q <= mark_d;
         space_q <= space_d;
         thresh_q <= thresh_d;
      end
   end

   assign mark_inc_o = mark_q;
   assign space_inc_o = space_q;
   assign thresh_o = thresh_q;
endmodule

// File: rtl/fsk_modem_top.sv
// fsk_modem_top: binary FSK modulator and period-measuring demodulator on an 8-in/8-out pin frame
module fsk_modem_top
   import fsk_modem_pkg::*;
(
   input  logic [7:0] io_in,
   output logic [7:0] io_out
);
   logic clk, rst, unused_io;
   logic [7:0] mark_inc, space_inc, thresh;
   logic [1:0] din_sync_q, smp_sync_q;
   logic [PHASE_W-1:0] phase_q, phase_d;
   logic [SAMPLE_W-1:0] samp_q, samp_d;
   logic [7:0] cnt_q, cnt_d;
   logic smp_prev_q, armed_q, armed_d, dout_q, dout_d, valid_q, valid_d, rise;

   assign clk = io_in[0];
   assign rst = io_in[1];
   assign unused_io = io_in[6];

   fsk_modem_if spi_bus ();
   assign spi_bus.cs_n = io_in[2];
   assign spi_bus.sck = io_in[3];
   assign spi_bus.mosi = io_in[4];

   fsk_spi_cfg u_cfg (
      .clk(clk),
      .rst(rst),
      .spi_i(spi_bus),
      .mark_inc_o(mark_inc),
      .space_inc_o(space_inc),
      .thresh_o(thresh)
   );

   always_ff @(posedge clk) begin
      din_sync_q <= {din_sync_q[0], io_in[5]};
      smp_sync_q <= {smp_sync_q[0], io_in[7]};
   end

   // armed_q marks that cnt spans a whole carrier period, so the next edge is a valid measurement
   always_comb begin
      phase_d = phase_q + (din_sync_q[1] ? mark_inc : space_inc);
      samp_d = sine_sample(phase_q[PHASE_W-1:PHASE_W-6]);
      rise = smp_sync_q[1] & ~smp_prev_q;
      cnt_d = rise ? 8'd1 : cnt_q + {7'd0, cnt_q != 8'hFF};
      dout_d = (rise && armed_q) ? (cnt_q < thresh) : dout_q;
      valid_d = (rise && armed_q && cnt_q >= 8'd2) ? 1'b1 : (!rise && cnt_d == TIMEOUT) ? 1'b0 : valid_q;
      armed_d = rise ? 1'b1 : (cnt_d == TIMEOUT) ? 1'b0 : armed_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         phase_q <= '0;
         samp_q <= 6'd32;
         cnt_q <= 8'd0;
         smp_prev_q <= 1'b0;
         armed_q <= 1'b0;
         dout_q <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         phase_q <= phase_d;
         samp_q <= samp_d;
         cnt_q <= cnt_d;
         smp_prev_q <= smp_sync_q[1];
         armed_q <= armed_d;
         dout_q <= dout_d;
         valid_q <= valid_d;
      end
   end

   assign io_out = {samp_q, valid_q, dout_q};
endmodule

// File: tb/tb_fsk_modem_top.sv
// tb_fsk_modem_top: directed checks of modulator, SPI config and demodulator
module tb_fsk_modem_top;
   logic clk, rst, data_in, man_drv, sq_wave, smp_pin;
   logic [1:0] mode;
   logic [7:0] io_in, io_out;
   int checks = 0;
   int errors = 0;

   localparam logic [5:0] EXP_SPACE [16] = '{6'd32, 6'd44, 6'd54, 6'd61, 6'd63, 6'd61, 6'd54, 6'd44,
                                             6'd32, 6'd20, 6'd10, 6'd3, 6'd1, 6'd3, 6'd10, 6'd20};
   localparam logic [5:0] EXP_MARK [12] = '{6'd32, 6'd44, 6'd54, 6'd63, 6'd54, 6'd32,
                                            6'd10, 6'd1, 6'd10, 6'd32, 6'd54, 6'd63};

   fsk_modem_if spi ();

   assign smp_pin = (mode == 2'd1) ? io_out[7] : (mode == 2'd2) ? sq_wave : man_drv;
   assign io_in = {smp_pin, 1'b0, data_in, spi.mosi, spi.sck, spi.cs_n, rst, clk};

   fsk_modem_top dut (
      .io_in(io_in),
      .io_out(io_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // free-running square wave, period 16 clk
   initial begin
      sq_wave = 1'b0;
      forever begin
         repeat (8) @(posedge clk);
         #1 sq_wave = ~sq_wave;
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic spi_frame(input logic [15:0] w, input int n);
      spi.cs_n = 1'b0;
      tick(5);
      for (int i = 0; i < n; i++) begin
         spi.mosi = w[15-i];
         tick(5);
         spi.sck = 1'b1;
         tick(5);
         spi.sck = 1'b0;
      end
      tick(5);
      spi.cs_n = 1'b1;
      tick(6);
   endtask

   task automatic check_mark32(input string tag);
      int n = 0;
      while (io_out[7:2] != 6'd63 && n < 40) begin
         tick(1);
         n++;
      end
      chk({tag, "_peak"}, 16'(io_out[7:2]), 16'd63);
      tick(16);
      chk({tag, "_trough"}, 16'(io_out[7:2]), 16'd1);
      tick(16);
      chk({tag, "_period"}, 16'(io_out[7:2]), 16'd63);
   endtask

   initial begin
      rst = 1'b1;
      data_in = 1'b0;
      man_drv = 1'b0;
      mode = 2'd0;
      spi.cs_n = 1'b1;
      spi.sck = 1'b0;
      spi.mosi = 1'b0;
      tick(5);
      chk("rst_samples", 16'(io_out[7:2]), 16'd32);
      chk("rst_valid", 16'(io_out[1]), 16'd0);
      chk("rst_data", 16'(io_out[0]), 16'd0);
      rst = 1'b0;
      for (int k = 0; k < 16; k++) begin
         tick(1);
         chk($sformatf("space_s%0d", k), 16'(io_out[7:2]), 16'(EXP_SPACE[k]));
      end
      data_in = 1'b1;
      for (int k = 0; k < 12; k++) begin
         tick(1);
         chk($sformatf("mark_s%0d", k), 16'(io_out[7:2]), 16'(EXP_MARK[k]));
      end
      spi_frame(16'h0008, 16);
      check_mark32("mark8");
      spi_frame(16'h0080, 15);
      spi_frame(16'h0540, 16);
      check_mark32("bad_frames");
      spi_frame(16'h0020, 16);
      mode = 2'd1;
      for (int w = 0; w < 4; w++) begin
         data_in = (w % 2 == 1);
         tick(64);
         chk($sformatf("loop_data_w%0d", w), 16'(io_out[0]), 16'(data_in));
         chk($sformatf("loop_valid_w%0d", w), 16'(io_out[1]), 16'd1);
      end
      mode = 2'd0;
      man_drv = 1'b0;
      tick(4);
      for (int i = 0; i < 4; i++) begin
         man_drv = 1'b1;
         tick(4);
         man_drv = 1'b0;
         tick(4);
      end
      man_drv = 1'b1;
      tick(64);
      chk("to_valid_cnt62", 16'(io_out[1]), 16'd1);
      tick(1);
      chk("to_valid_cnt63", 16'(io_out[1]), 16'd0);
      chk("to_data_hold", 16'(io_out[0]), 16'd1);
      tick(5);
      chk("to_data_hold2", 16'(io_out[0]), 16'd1);
      mode = 2'd2;
      tick(80);
      chk("thr12_data", 16'(io_out[0]), 16'd0);
      chk("thr12_valid", 16'(io_out[1]), 16'd1);
      spi_frame(16'h0214, 16);
      tick(24);
      chk("thr20_data", 16'(io_out[0]), 16'd1);
      spi_frame(16'h0210, 16);
      tick(24);
      chk("thr16_data", 16'(io_out[0]), 16'd0);
      spi_frame(16'h0211, 16);
      tick(24);
      chk("thr17_data", 16'(io_out[0]), 16'd1);
      spi_frame(16'h020A, 16);
      tick(24);
      chk("thr10_data", 16'(io_out[0]), 16'd0);
      chk("thr10_valid", 16'(io_out[1]), 16'd1);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
